// File: rtl/am2910_seq.sv
`default_nettype none
// ============================================================================
// Module   : am2910_seq
// Brief    : Am2910-style microprogram sequencer (uPC, loop counter, LIFO stack)
// Revision : 1.0 - initial release
// ============================================================================
module am2910_seq #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       instr,
   input  logic [WIDTH-1:0] d,
   input  logic             cc_n,
   input  logic             ccen_n,
   input  logic             ci,
   input  logic             rld_n,
   output logic [WIDTH-1:0] y,
   output logic             full_n,
   output logic             pl_n,
   output logic             map_n,
   output logic             vect_n
);

   localparam int             SPW     = $clog2(DEPTH + 1);
   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

   localparam logic [3:0] OP_JZ   = 4'd0;
   localparam logic [3:0] OP_CJS  = 4'd1;
   localparam logic [3:0] OP_JMAP = 4'd2;
   localparam logic [3:0] OP_CJP  = 4'd3;
   localparam logic [3:0] OP_PUSH = 4'd4;
   localparam logic [3:0] OP_JSRP = 4'd5;
   localparam logic [3:0] OP_CJV  = 4'd6;
   localparam logic [3:0] OP_JRP  = 4'd7;
   localparam logic [3:0] OP_RFCT = 4'd8;
   localparam logic [3:0] OP_RPCT = 4'd9;
   localparam logic [3:0] OP_CRTN = 4'd10;
   localparam logic [3:0] OP_CJPP = 4'd11;
   localparam logic [3:0] OP_LDCT = 4'd12;
   localparam logic [3:0] OP_LOOP = 4'd13;
   localparam logic [3:0] OP_TWB  = 4'd15;

   logic [WIDTH-1:0] upc_q, upc_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [SPW-1:0]   sp_q, sp_d;
   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [WIDTH-1:0] stack_d [DEPTH];

   logic             pass, rz;
   logic             push, pop, clear, dec, cload;
   logic [WIDTH-1:0] top;
   logic [SPW-1:0]   wr_idx;

   assign pass   = ccen_n | ~cc_n;
   assign rz     = (r_q == '0);
   // An empty stack reads as zero rather than a stale entry.
   assign top    = (sp_q == '0) ? '0 : stack_q[sp_q - SPW'(1)];
   assign full_n = (sp_q != SP_FULL);

   always_comb begin
      y      = upc_q;
      pl_n   = 1'b0;
      map_n  = 1'b1;
      vect_n = 1'b1;
      push   = 1'b0;
      pop    = 1'b0;
      clear  = 1'b0;
      dec    = 1'b0;
      cload  = 1'b0;
      case (instr)
         OP_JZ:   begin y = '0; clear = 1'b1; end
         OP_CJS:  if (pass) begin y = d; push = 1'b1; end
         OP_JMAP: begin y = d; pl_n = 1'b1; map_n = 1'b0; end
         OP_CJP:  if (pass) y = d;
         OP_PUSH: begin push = 1'b1; cload = pass; end
         OP_JSRP: begin push = 1'b1; y = pass ? d : r_q; end
         OP_CJV:  begin pl_n = 1'b1; vect_n = 1'b0; if (pass) y = d; end
         OP_JRP:  y = pass ? d : r_q;
         OP_RFCT: if (rz) pop = 1'b1; else begin y = top; dec = 1'b1; end
         OP_RPCT: if (!rz) begin y = d; dec = 1'b1; end
         OP_CRTN: if (pass) begin y = top; pop = 1'b1; end
         OP_CJPP: if (pass) begin y = d; pop = 1'b1; end
         OP_LDCT: cload = 1'b1;
         OP_LOOP: if (pass) pop = 1'b1; else y = top;
         OP_TWB: begin
            if (pass) begin
               pop = 1'b1;
            end else if (rz) begin
               y   = d;
               pop = 1'b1;
            end else begin
               y   = top;
               dec = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      upc_d = y + WIDTH'(ci);

      // External load wins over both decrement and instruction loads.
      r_d = r_q;
      if (dec)
         r_d = r_q - WIDTH'(1);
      if (cload || !rld_n)
         r_d = d;

      // A push onto a full stack overwrites the top entry in place.
      stack_d = stack_q;
      sp_d    = sp_q;
      wr_idx  = (sp_q == SP_FULL) ? (SP_FULL - SPW'(1)) : sp_q;
      if (clear) begin
         sp_d = '0;
      end else if (push) begin
         stack_d[wr_idx] = upc_q;
         if (sp_q != SP_FULL)
            sp_d = sp_q + SPW'(1);
      end else if (pop && (sp_q != '0)) begin
         sp_d = sp_q - SPW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         upc_q <= '0;
         r_q   <= '0;
         sp_q  <= '0;
         for (int i = 0; i < DEPTH; i++)
            stack_q[i] <= '0;
      end else begin
         upc_q   <= upc_d;
         r_q     <= r_d;
         sp_q    <= sp_d;
         stack_q <= stack_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_am2910_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_am2910_seq
// Brief    : Directed + randomized bench for am2910_seq against a queue model
// Revision : 1.0 - initial release
// ============================================================================
module tb_am2910_seq;

   localparam int W     = 12;
   localparam int DEPTH = 5;

   localparam logic [3:0] JZ   = 4'd0;
   localparam logic [3:0] CJS  = 4'd1;
   localparam logic [3:0] CJP  = 4'd3;
   localparam logic [3:0] PUSH = 4'd4;
   localparam logic [3:0] JRP  = 4'd7;
   localparam logic [3:0] RFCT = 4'd8;
   localparam logic [3:0] RPCT = 4'd9;
   localparam logic [3:0] CRTN = 4'd10;
   localparam logic [3:0] LDCT = 4'd12;
   localparam logic [3:0] CONT = 4'd14;

   logic         clock  = 1'b0;
   logic         reset  = 1'b1;
   logic [3:0]   instr  = 4'd14;
   logic [W-1:0] d      = '0;
   logic         cc_n   = 1'b1;
   logic         ccen_n = 1'b1;
   logic         ci     = 1'b0;
   logic         rld_n  = 1'b1;
   logic [W-1:0] y;
   logic         full_n, pl_n, map_n, vect_n;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] m_upc, m_r;
   logic [W-1:0] m_stk[$];

   am2910_seq #(.WIDTH(W), .DEPTH(DEPTH)) dut (
      .clock  (clock),
      .reset  (reset),
      .instr  (instr),
      .d      (d),
      .cc_n   (cc_n),
      .ccen_n (ccen_n),
      .ci     (ci),
      .rld_n  (rld_n),
      .y      (y),
      .full_n (full_n),
      .pl_n   (pl_n),
      .map_n  (map_n),
      .vect_n (vect_n)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] m_top();
      return (m_stk.size() == 0) ? '0 : m_stk[m_stk.size() - 1];
   endfunction

   function automatic logic [W-1:0] model_y();
      logic p;
      logic z;
      p = ccen_n | ~cc_n;
      z = (m_r == '0);
      case (instr)
         4'd0:  return '0;
         4'd1:  return p ? d : m_upc;
         4'd2:  return d;
         4'd3:  return p ? d : m_upc;
         4'd4:  return m_upc;
         4'd5:  return p ? d : m_r;
         4'd6:  return p ? d : m_upc;
         4'd7:  return p ? d : m_r;
         4'd8:  return z ? m_upc : m_top();
         4'd9:  return z ? m_upc : d;
         4'd10: return p ? m_top() : m_upc;
         4'd11: return p ? d : m_upc;
         4'd13: return p ? m_upc : m_top();
         4'd15: return p ? m_upc : (z ? d : m_top());
         default: return m_upc;
      endcase
   endfunction

   task automatic m_reset();
      m_upc = '0;
      m_r   = '0;
      m_stk.delete();
   endtask

   task automatic m_push(input logic [W-1:0] v);
      if (m_stk.size() == DEPTH)
         m_stk[DEPTH-1] = v;
      else
         m_stk.push_back(v);
   endtask

   task automatic m_pop();
      if (m_stk.size() > 0)
         void'(m_stk.pop_back());
   endtask

   task automatic drive(input logic [3:0] op, input logic [W-1:0] dv, input logic c,
                        input logic ce, input logic cin, input logic rl);
      instr  = op;
      d      = dv;
      cc_n   = c;
      ccen_n = ce;
      ci     = cin;
      rld_n  = rl;
      #2;
   endtask

   task automatic chk_model(input string tag);
      logic [2:0] es;
      es = (instr == 4'd2) ? 3'b101 : (instr == 4'd6) ? 3'b110 : 3'b011;
      chk({tag, "_y"}, y, model_y());
      chk({tag, "_full"}, W'(full_n), W'(m_stk.size() != DEPTH));
      chk({tag, "_src"}, W'({pl_n, map_n, vect_n}), W'(es));
   endtask

   // Advance one clock and apply the instruction's effect to the model.
   task automatic tick();
      logic         p, z;
      logic [W-1:0] yv, old;
      p   = ccen_n | ~cc_n;
      z   = (m_r == '0);
      yv  = model_y();
      old = m_upc;
      @(posedge clock);
      #1;
      case (instr)
         4'd0:  m_stk.delete();
         4'd1:  if (p) m_push(old);
         4'd4:  begin m_push(old); if (p) m_r = d; end
         4'd5:  m_push(old);
         4'd8:  if (!z) m_r = m_r - 1'b1; else m_pop();
         4'd9:  if (!z) m_r = m_r - 1'b1;
         4'd10, 4'd11, 4'd13: if (p) m_pop();
         4'd12: m_r = d;
         4'd15: if (!p && !z) m_r = m_r - 1'b1; else m_pop();
         default: ;
      endcase
      if (!rld_n)
         m_r = d;
      m_upc = yv + W'(ci);
   endtask

   task automatic run(input logic [3:0] op, input logic [W-1:0] dv, input logic c,
                      input logic ce, input logic cin, input logic rl, input string tag);
      drive(op, dv, c, ce, cin, rl);
      chk_model(tag);
      tick();
   endtask

   task automatic run_exp(input logic [3:0] op, input logic [W-1:0] dv, input logic c,
                          input logic ce, input logic cin, input logic rl,
                          input string tag, input logic [W-1:0] exp);
      drive(op, dv, c, ce, cin, rl);
      chk(tag, y, exp);
      chk_model(tag);
      tick();
   endtask

   initial begin
      logic [W-1:0] pops [5];
      pops = '{12'd6, 12'd4, 12'd3, 12'd2, 12'd1};
      m_reset();

      // Cleared state while reset is held; edges must not advance uPC.
      #12;
      drive(CONT, 12'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("rst_y", y, 12'h000);
      chk("rst_full", W'(full_n), 12'h001);
      @(posedge clock);
      #1;
      chk("rst_hold", y, 12'h000);
      @(negedge clock);
      reset = 1'b0;

      run_exp(CONT, 12'h0, 1'b1, 1'b1, 1'b1, 1'b1, "cont0", 12'h000);
      run_exp(CONT, 12'h0, 1'b1, 1'b1, 1'b1, 1'b1, "cont1", 12'h001);
      run_exp(CONT, 12'h0, 1'b1, 1'b1, 1'b1, 1'b1, "cont2", 12'h002);
      run_exp(CONT, 12'h0, 1'b1, 1'b1, 1'b0, 1'b1, "upc3",  12'h003);

      run_exp(CJP,  12'h010, 1'b0, 1'b0, 1'b0, 1'b1, "cjp",   12'h010);
      run_exp(CJS,  12'h100, 1'b0, 1'b0, 1'b0, 1'b1, "cjs",   12'h100);
      run_exp(CRTN, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, "crtn",  12'h010);
      run_exp(CRTN, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, "crtn_empty", 12'h000);

      run_exp(LDCT, 12'h002, 1'b1, 1'b1, 1'b1, 1'b1, "ldct",  12'h000);
      run_exp(RPCT, 12'h050, 1'b1, 1'b1, 1'b1, 1'b1, "rpct1", 12'h050);
      run_exp(RPCT, 12'h050, 1'b1, 1'b1, 1'b1, 1'b1, "rpct2", 12'h050);
      run_exp(RPCT, 12'h050, 1'b1, 1'b1, 1'b1, 1'b1, "rpct3", 12'h051);
      run_exp(JRP,  12'h000, 1'b1, 1'b0, 1'b0, 1'b1, "r_zero", 12'h000);

      // Stack overflow: the sixth push replaces the fifth entry.
      run_exp(CONT, 12'h0, 1'b1, 1'b1, 1'b1, 1'b1, "pre_push", 12'h000);
      for (int i = 1; i <= 6; i++) begin
         drive(PUSH, 12'h0, 1'b1, 1'b0, 1'b1, 1'b1);
         chk($sformatf("push%0d_y", i), y, W'(i));
         chk($sformatf("push%0d_full", i), W'(full_n), W'(i <= 5));
         chk_model($sformatf("push%0d", i));
         tick();
      end
      drive(CONT, 12'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("full_after6", W'(full_n), 12'h000);
      for (int i = 0; i < 5; i++)
         run_exp(CRTN, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("pop%0d", i), pops[i]);
      run_exp(CRTN, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1, "pop_underflow", 12'h000);

      run_exp(CJP,  12'h123, 1'b0, 1'b0, 1'b0, 1'b1, "rld_cjp",  12'h123);
      run_exp(PUSH, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, "rld_push", 12'h123);
      run_exp(LDCT, 12'h003, 1'b1, 1'b1, 1'b1, 1'b1, "rld_ldct", 12'h124);
      run_exp(RFCT, 12'h007, 1'b1, 1'b1, 1'b1, 1'b0, "rld_rfct", 12'h123);
      run_exp(JRP,  12'h000, 1'b1, 1'b0, 1'b0, 1'b1, "rld_r7",   12'h007);

      run_exp(CJP,  12'hFFF, 1'b0, 1'b0, 1'b1, 1'b1, "wrap_jmp", 12'hFFF);
      run_exp(CONT, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1, "wrap_0",   12'h000);

      // Deep nest, then asynchronous reset between edges.
      run(JZ, 12'h0, 1'b1, 1'b1, 1'b0, 1'b1, "nest_clr");
      for (int i = 0; i < 5; i++)
         run(CJS, W'(12'h200 + 12'h100 * i), 1'b0, 1'b0, 1'b1, 1'b1, $sformatf("nest%0d", i));
      run(LDCT, 12'h005, 1'b1, 1'b1, 1'b1, 1'b1, "nest_ldct");
      drive(CONT, 12'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("nest_full", W'(full_n), 12'h000);
      reset = 1'b1;
      m_reset();
      #1;
      chk("arst_upc", y, 12'h000);
      chk("arst_full", W'(full_n), 12'h001);
      drive(JRP, 12'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("arst_r", y, 12'h000);
      drive(CRTN, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("arst_sp", y, 12'h000);
      drive(CONT, 12'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      @(posedge clock);
      #1;
      chk("arst_hold", y, 12'h000);
      @(negedge clock);
      reset = 1'b0;
      run_exp(CONT, 12'h0, 1'b1, 1'b1, 1'b1, 1'b1, "resume0", 12'h000);
      run_exp(CONT, 12'h0, 1'b1, 1'b1, 1'b1, 1'b1, "resume1", 12'h001);

      for (int n = 0; n < 600; n++) begin
         logic [3:0]   op;
         logic [W-1:0] dv;
         op = ($urandom_range(0, 29) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         dv = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 4));
         run(op, dv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) != 0),
             $sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
